// File: rtl/attractor_sweeper.sv
`default_nettype none
// attractor_sweeper: sweeps a range of init values through gene_net and classifies each
// trajectory as fixed point, cycle or timeout from a bounded history of sampled states.
module attractor_sweeper #(
  parameter int MAX_STEPS = 16,
  parameter int LEN_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       first_val,
  input  logic [7:0]       last_val,
  output logic [7:0]       init_val,
  output logic             load,
  input  logic [7:0]       x_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_init,
  output logic [1:0]       res_class,
  output logic [LEN_W-1:0] res_len,
  output logic [7:0]       res_attr,
  output logic             busy,
  output logic             done,
  output logic [8:0]       n_fixed,
  output logic [8:0]       n_cycle,
  output logic [8:0]       n_timeout
);

  localparam int STEP_W = $clog2(MAX_STEPS);

  localparam logic [1:0] CLS_FIXED   = 2'b00;
  localparam logic [1:0] CLS_CYCLE   = 2'b01;
  localparam logic [1:0] CLS_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_TRACK  = 3'd2,
    S_REPORT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state;
  logic [7:0]        idx;
  logic [7:0]        last_r;
  logic [STEP_W-1:0] step;
  logic [7:0]        hist [MAX_STEPS];

  logic              hit;
  logic [STEP_W-1:0] hit_idx;
  logic [LEN_W-1:0]  hit_len;
  logic              last_init;
  logic              hist_full;

  // Later indices overwrite earlier ones, so the most recent match (shortest cycle) wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < MAX_STEPS; i++) begin
      if ((STEP_W'(i) < step) && (hist[i] == x_in)) begin
        hit     = 1'b1;
        hit_idx = STEP_W'(i);
      end
    end
  end

  assign hit_len   = LEN_W'(step) - LEN_W'(hit_idx);
  assign hist_full = (step == STEP_W'(MAX_STEPS - 1));
  // ">=" rather than "==" so a reversed range yields a single result and 255 never wraps.
  assign last_init = (idx >= last_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      last_r    <= '0;
      step      <= '0;
      hist      <= '{default: '0};
      init_val  <= '0;
      load      <= 1'b0;
      res_valid <= 1'b0;
      res_init  <= '0;
      res_class <= '0;
      res_len   <= '0;
      res_attr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      n_fixed   <= '0;
      n_cycle   <= '0;
      n_timeout <= '0;
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx       <= first_val;
            last_r    <= last_val;
            n_fixed   <= '0;
            n_cycle   <= '0;
            n_timeout <= '0;
            busy      <= 1'b1;
            init_val  <= first_val;
            load      <= 1'b1;
            state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          step  <= '0;
          state <= S_TRACK;
        end

        S_TRACK: begin
          hist[step] <= x_in;
          if (hit) begin
            res_init  <= idx;
            res_class <= (hit_len == LEN_W'(1)) ? CLS_FIXED : CLS_CYCLE;
            res_len   <= hit_len;
            res_attr  <= x_in;
            res_valid <= 1'b1;
            state     <= S_REPORT;
          end else if (hist_full) begin
            res_init  <= idx;
            res_class <= CLS_TIMEOUT;
            res_len   <= '0;
            res_attr  <= x_in;
            res_valid <= 1'b1;
            state     <= S_REPORT;
          end else begin
            step <= step + STEP_W'(1);
          end
        end

        S_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            case (res_class)
              CLS_FIXED: n_fixed   <= n_fixed + 9'd1;
              CLS_CYCLE: n_cycle   <= n_cycle + 9'd1;
              default:   n_timeout <= n_timeout + 9'd1;
            endcase
            if (last_init) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx      <= idx + 8'd1;
              init_val <= idx + 8'd1;
              load     <= 1'b1;
              state    <= S_LOAD;
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_attractor_sweeper.sv
`default_nettype none
// Self-checking bench for attractor_sweeper: a table-driven network model feeds x_in and a
// trajectory-search reference model predicts every result and the per-sweep counters.
module tb_attractor_sweeper;

  localparam int MS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] first_val, last_val;
  logic [7:0] init_val;
  logic       load;
  logic [7:0] x;
  logic       res_valid, res_ready;
  logic [7:0] res_init;
  logic [1:0] res_class;
  logic [4:0] res_len;
  logic [7:0] res_attr;
  logic       busy, done;
  logic [8:0] n_fixed, n_cycle, n_timeout;

  logic       start2;
  logic [7:0] first_val2, last_val2;
  logic [7:0] init_val2;
  logic       load2;
  logic [7:0] x2;
  logic       res_valid2, res_ready2;
  logic [7:0] res_init2;
  logic [1:0] res_class2;
  logic [4:0] res_len2;
  logic [7:0] res_attr2;
  logic       busy2, done2;
  logic [8:0] n_fixed2, n_cycle2, n_timeout2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] map [256];

  always #5 clk = ~clk;

  attractor_sweeper #(.MAX_STEPS(MS), .LEN_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_val(first_val), .last_val(last_val),
    .init_val(init_val), .load(load), .x_in(x), .res_valid(res_valid), .res_ready(res_ready),
    .res_init(res_init), .res_class(res_class), .res_len(res_len), .res_attr(res_attr),
    .busy(busy), .done(done), .n_fixed(n_fixed), .n_cycle(n_cycle), .n_timeout(n_timeout)
  );

  attractor_sweeper #(.MAX_STEPS(2), .LEN_W(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .first_val(first_val2), .last_val(last_val2),
    .init_val(init_val2), .load(load2), .x_in(x2), .res_valid(res_valid2),
    .res_ready(res_ready2), .res_init(res_init2), .res_class(res_class2),
    .res_len(res_len2), .res_attr(res_attr2), .busy(busy2), .done(done2),
    .n_fixed(n_fixed2), .n_cycle(n_cycle2), .n_timeout(n_timeout2)
  );

  // Network stand-in: loads init on the load pulse, then follows the map one step per clock.
  always @(posedge clk) begin
    x  <= load  ? init_val  : map[x];
    x2 <= load2 ? init_val2 : map[x2];
  end

  function automatic void build_map();
    for (int v = 0; v < 256; v++) map[v] = 8'($urandom_range(0, 255));
    for (int n = 0; n < 12; n++) begin
      int v = $urandom_range(0, 255);
      map[v] = 8'(v);
    end
    map[8'h00] = 8'h00;
    map[8'h63] = 8'h53;
    map[8'h53] = 8'h53;
    map[8'hFF] = 8'h53;
    map[8'h38] = 8'h1C;
    map[8'h1C] = 8'h2A;
    map[8'h2A] = 8'h38;
    map[8'h7C] = 8'h7D;
    map[8'h7D] = 8'h7E;
  endfunction

  // Trajectory s0=init, s(k)=map(s(k-1)); the first s(k) equal to an earlier sample ends it.
  function automatic void ref_traj(input logic [7:0] init, input int ms,
                                   output logic [1:0] cls, output logic [4:0] len,
                                   output logic [7:0] attr);
    logic [7:0] s[$];
    logic [7:0] nxt;
    s.push_back(init);
    for (int k = 1; k < ms; k++) begin
      nxt = map[s[k-1]];
      for (int j = k - 1; j >= 0; j--) begin
        if (s[j] == nxt) begin
          len  = 5'(k - j);
          cls  = ((k - j) == 1) ? 2'b00 : 2'b01;
          attr = nxt;
          return;
        end
      end
      s.push_back(nxt);
    end
    cls  = 2'b10;
    len  = 5'd0;
    attr = s[s.size()-1];
  endfunction

  // mode 0: ready held high, 1: random ready, 2: stall the first result for 10 cycles.
  // poke: random start pulses while busy, plus one in the same cycle as done.
  task automatic run_sweep(input logic [7:0] f, input logic [7:0] l, input int mode,
                           input bit poke);
    logic [7:0]  exp_q[$];
    logic [8:0]  e_fix, e_cyc, e_to;
    logic [1:0]  c;
    logic [4:0]  ln;
    logic [7:0]  a;
    logic [22:0] prev, cur, expv;
    bit          held, got_done, rdy;
    int          idx, hold_cnt, budget;
    e_fix = 0; e_cyc = 0; e_to = 0;
    if (f > l) exp_q.push_back(f);
    else for (int v = int'(f); v <= int'(l); v++) exp_q.push_back(8'(v));
    foreach (exp_q[i]) begin
      ref_traj(exp_q[i], MS, c, ln, a);
      if (c == 2'b00) e_fix++; else if (c == 2'b01) e_cyc++; else e_to++;
    end
    @(negedge clk);
    first_val = f; last_val = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0; first_val = 8'($urandom); last_val = 8'($urandom);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_start: got %b want 1", busy);
    end
    held = 0; got_done = 0; idx = 0; hold_cnt = 0; prev = '0;
    budget = (exp_q.size() + 1) * (MS + 60) + 100;
    for (int cyc = 0; cyc < budget && !got_done; cyc++) begin
      cur = {res_init, res_class, res_len, res_attr};
      if (load) begin
        n_checks++;
        if (idx >= exp_q.size() || init_val !== exp_q[idx]) begin
          n_fail++; $display("FAIL load_init_val: got %h want %h (result %0d)", init_val,
                             (idx < exp_q.size()) ? exp_q[idx] : 8'hxx, idx);
        end
      end
      if (res_valid) begin
        n_checks++;
        if (load !== 1'b0) begin
          n_fail++; $display("FAIL load_during_report: got %b want 0", load);
        end
      end
      if (held) begin
        n_checks++;
        if (res_valid !== 1'b1 || cur !== prev) begin
          n_fail++; $display("FAIL payload_stable: got valid=%b %h want valid=1 %h",
                             res_valid, cur, prev);
        end
      end
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = 1'($urandom_range(0, 1));
      else begin
        rdy = !(idx == 0 && res_valid && hold_cnt < 10);
        if (idx == 0 && res_valid) hold_cnt++;
      end
      res_ready = rdy;
      if (res_valid && rdy) begin
        if (idx < exp_q.size()) begin
          ref_traj(exp_q[idx], MS, c, ln, a);
          expv = {exp_q[idx], c, ln, a};
        end else expv = 'x;
        n_checks++;
        if (cur !== expv) begin
          n_fail++;
          $display("FAIL result: got init=%h class=%b len=%0d attr=%h want init=%h class=%b len=%0d attr=%h",
                   res_init, res_class, res_len, res_attr, expv[22:15], expv[14:13],
                   expv[12:8], expv[7:0]);
        end
        idx++;
        held = 0;
      end else begin
        held = res_valid;
        prev = cur;
      end
      if (done) begin
        got_done = 1;
        n_checks++;
        if (idx != exp_q.size()) begin
          n_fail++; $display("FAIL result_count_at_done: got %0d want %0d", idx, exp_q.size());
        end
        if (poke) begin
          start = 1'b1; first_val = 8'h10; last_val = 8'h20;
        end
      end else if (poke && busy && $urandom_range(0, 15) == 0) begin
        start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    res_ready = 1'b0;
    n_checks++;
    if (!got_done) begin
      n_fail++; $display("FAIL sweep_timeout: got no done want done within %0d cycles", budget);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_done: got busy=%b done=%b want 0 0", busy, done);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({n_fixed, n_cycle, n_timeout} !== {e_fix, e_cyc, e_to} || busy !== 1'b0) begin
      n_fail++; $display("FAIL counters: got fix=%0d cyc=%0d to=%0d busy=%b want %0d %0d %0d 0",
                         n_fixed, n_cycle, n_timeout, busy, e_fix, e_cyc, e_to);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({init_val, load, res_valid, res_init, res_class, res_len, res_attr, busy, done,
         n_fixed, n_cycle, n_timeout} !== '0) begin
      n_fail++;
      $display("FAIL %s: got init=%h load=%b valid=%b res=%h/%b/%0d/%h busy=%b done=%b n=%0d/%0d/%0d want all 0",
               name, init_val, load, res_valid, res_init, res_class, res_len, res_attr,
               busy, done, n_fixed, n_cycle, n_timeout);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fixed_zero();
    run_sweep(8'h00, 8'h00, 0, 0);
    n_checks++;
    if ({res_init, res_class, res_len, res_attr, n_fixed} !== {8'h00, 2'b00, 5'd1, 8'h00, 9'd1}) begin
      n_fail++; $display("FAIL fixed_zero: got %h/%b/%0d/%h n_fixed=%0d want 00/00/1/00 1",
                         res_init, res_class, res_len, res_attr, n_fixed);
    end
  endtask

  task automatic test_fixed_63();
    run_sweep(8'h63, 8'h63, 1, 0);
    n_checks++;
    if ({res_class, res_len, res_attr, n_fixed, n_cycle} !== {2'b00, 5'd1, 8'h53, 9'd1, 9'd0}) begin
      n_fail++; $display("FAIL fixed_63: got %b/%0d/%h fix=%0d cyc=%0d want 00/1/53 1 0",
                         res_class, res_len, res_attr, n_fixed, n_cycle);
    end
  endtask

  task automatic test_cycle_38();
    run_sweep(8'h38, 8'h38, 0, 1);
    n_checks++;
    if ({res_class, res_len, res_attr, n_cycle} !== {2'b01, 5'd3, 8'h38, 9'd1}) begin
      n_fail++; $display("FAIL cycle_38: got %b/%0d/%h cyc=%0d want 01/3/38 1",
                         res_class, res_len, res_attr, n_cycle);
    end
  endtask

  task automatic test_backpressure();
    run_sweep(8'h7C, 8'hFF, 2, 0);
    n_checks++;
    if ({res_init, res_class, res_attr} !== {8'hFF, 2'b00, 8'h53} ||
        (n_fixed + n_cycle + n_timeout) !== 9'd132) begin
      n_fail++; $display("FAIL backpressure_last: got %h/%b/%h sum=%0d want FF/00/53 132",
                         res_init, res_class, res_attr, n_fixed + n_cycle + n_timeout);
    end
  endtask

  task automatic test_reversed_range();
    run_sweep(8'h90, 8'h10, 1, 1);
    n_checks++;
    if (res_init !== 8'h90 || (n_fixed + n_cycle + n_timeout) !== 9'd1) begin
      n_fail++; $display("FAIL reversed_range: got init=%h sum=%0d want 90 1",
                         res_init, n_fixed + n_cycle + n_timeout);
    end
  endtask

  task automatic test_random_ranges();
    for (int t = 0; t < 4; t++) begin
      logic [7:0] f, l;
      f = 8'($urandom_range(0, 240));
      l = f + 8'($urandom_range(0, 15));
      run_sweep(f, l, 1, 1);
    end
  endtask

  task automatic test_short_history();
    logic [1:0] c;
    logic [4:0] ln;
    logic [7:0] a;
    bit         seen, fin;
    ref_traj(8'h7C, 2, c, ln, a);
    res_ready2 = 1'b1;
    @(negedge clk);
    first_val2 = 8'h7C; last_val2 = 8'h7C; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    seen = 0; fin = 0;
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      if (res_valid2 && !seen) begin
        seen = 1;
        n_checks++;
        if ({res_init2, res_class2, res_len2, res_attr2} !== {8'h7C, c, ln, a} ||
            {res_class2, res_len2} !== {2'b10, 5'd0}) begin
          n_fail++; $display("FAIL short_history: got %h/%b/%0d/%h want 7C/10/0/%h",
                             res_init2, res_class2, res_len2, res_attr2, a);
        end
      end
      if (done2) fin = 1;
      @(negedge clk);
    end
    n_checks++;
    if (!seen || !fin || {n_fixed2, n_cycle2, n_timeout2} !== {9'd0, 9'd0, 9'd1}) begin
      n_fail++; $display("FAIL short_history_count: got seen=%b done=%b n=%0d/%0d/%0d want 1 1 0/0/1",
                         seen, fin, n_fixed2, n_cycle2, n_timeout2);
    end
  endtask

  task automatic test_reset_midtrack();
    bit found;
    @(negedge clk);
    first_val = 8'h3E; last_val = 8'h50; start = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 2000 && !found; cyc++) begin
      if (load && init_val == 8'h40) found = 1;
      else @(negedge clk);
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL midtrack_reach: got no load of 40 want load of 40");
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midtrack_async_reset");
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("midtrack_reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(8'h00, 8'hFF, 1, 1);
    n_checks++;
    if ((n_fixed + n_cycle + n_timeout) !== 9'd256) begin
      n_fail++; $display("FAIL full_sweep_sum: got %0d want 256", n_fixed + n_cycle + n_timeout);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; first_val = '0; last_val = '0; res_ready = 1'b0;
    start2 = 1'b0; first_val2 = '0; last_val2 = '0; res_ready2 = 1'b0;
    x = '0; x2 = '0;
    build_map();
    test_reset();
    test_fixed_zero();
    test_fixed_63();
    test_cycle_38();
    test_backpressure();
    test_reversed_range();
    test_random_ranges();
    test_short_history();
    test_reset_midtrack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
